adiabatic_pclk_sequencer: RTL and testbench

//  Digital sequencer for the 4-phase adiabatic power clocks that feed clkpos/clkneg of adiabatic gates (inverter/FO-N cells).

---
 rtl/adiabatic_pkg.sv | 29 ++
 rtl/adiabatic_ramp_gen.sv | 62 ++++++
 rtl/adiabatic_pclk_sequencer.sv | 138 +++++++++++++
 tb/tb_adiabatic_pclk_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adiabatic_pkg.sv
// Shared types and helpers for the adiabatic power-clock sequencer.
//   phase_e      : per-group power-clock phase (RAMP_UP, HOLD, RAMP_DN, WAIT)
//   seq_state_e  : sequencer FSM state (IDLE, FILL, RUN, DRAIN)
//   NPHASE       : number of phases in one power-clock period (fixed at 4)
//   safe_clog2   : counter width helper that never returns 0
package adiabatic_pkg;

    localparam int NPHASE = 4;

    typedef enum logic [1:0] {
        PH_RAMP_UP = 2'd0,
        PH_HOLD    = 2'd1,
        PH_RAMP_DN = 2'd2,
        PH_WAIT    = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    // A counter over n values needs at least one bit even when n == 1.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adiabatic_ramp_gen.sv
// Per-group level generator: maps the group's current phase and the shared
// step index onto a registered clkpos level code, plus the complementary
// clkneg code.
// Optional feature macro: ADIABATIC_CLKNEG_EN
//   defined     : clkneg_lvl = STEPS - clkpos_lvl, registered in the same cycle
//   not defined : clkneg_lvl tied to 0 (single-rail clocking)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   phase        : current phase of this group
//   step_idx     : charge step within the current phase, 0..STEPS-1
//   clkpos_lvl   : registered rail-select level code, 0..STEPS
//   clkneg_lvl   : complementary level code (see macro above)
module adiabatic_ramp_gen
    import adiabatic_pkg::*;
#(
    parameter  int STEPS = 8,
    localparam int LW    = $clog2(STEPS + 1),
    localparam int SW    = safe_clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  phase_e        phase,
    input  logic [SW-1:0] step_idx,
    output logic [LW-1:0] clkpos_lvl,
    output logic [LW-1:0] clkneg_lvl
);

    logic [LW-1:0] lvl_nx;

    // Ramp up ends on STEPS and ramp down ends on 0, so every transition
    // between neighbouring phases moves the level by at most one code.
    always_comb begin
        lvl_nx = '0;
        unique case (phase)
            PH_RAMP_UP: lvl_nx = LW'(step_idx) + LW'(1);
            PH_HOLD:    lvl_nx = LW'(STEPS);
            PH_RAMP_DN: lvl_nx = LW'(STEPS - 1) - LW'(step_idx);
            default:    lvl_nx = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkpos_lvl <= '0;
        end else begin
            clkpos_lvl <= lvl_nx;
        end
    end

`ifdef ADIABATIC_CLKNEG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkneg_lvl <= LW'(STEPS);
        end else begin
            clkneg_lvl <= LW'(STEPS) - lvl_nx;
        end
    end
`else
    assign clkneg_lvl = '0;
`endif

endmodule

// File: rtl/adiabatic_pclk_sequencer.sv
// Sequencer for 4-phase adiabatic power clocks. Group g lags group g-1 by one
// phase; each phase lasts STEPS*STEP_CYC cycles. Start-up fills the pipeline
// one group per phase, shutdown drains it without ever starting a new ramp.
// Optional feature macro: ADIABATIC_CLKNEG_EN (complementary clkneg levels,
// implemented in adiabatic_ramp_gen).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   run_req      : level request, 1 = run power clocks, 0 = drain and stop
//   busy         : high while the sequencer is not IDLE
//   phase_tick   : one-cycle pulse on the last cycle of every phase
//   grp_phase    : per-group phase_e, group g at [2g+1:2g]
//   clkpos_lvl   : per-group level code, group g at [LW*g +: LW]
//   clkneg_lvl   : per-group complementary level code
//   dbg_state    : current FSM state, for observation only
// run_req is a plain level, not a handshake: IDLE starts on any sampled 1,
// FILL/RUN latch a drain on any sampled 0, and DRAIN ignores it.
module adiabatic_pclk_sequencer
    import adiabatic_pkg::*;
#(
    parameter  int STEPS    = 8,
    parameter  int STEP_CYC = 4,
    localparam int NGRP     = NPHASE,
    localparam int LW       = $clog2(STEPS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_req,
    output logic               busy,
    output logic               phase_tick,
    output logic [2*NGRP-1:0]  grp_phase,
    output logic [LW*NGRP-1:0] clkpos_lvl,
    output logic [LW*NGRP-1:0] clkneg_lvl,
    output seq_state_e         dbg_state
);

    localparam int SW = safe_clog2(STEPS);
    localparam int CW = safe_clog2(STEP_CYC);

    seq_state_e    state, state_nx;
    logic [CW-1:0] cyc_cnt;
    logic [SW-1:0] step_idx;
    logic [1:0]    gphase;
    logic [1:0]    gnext;
    logic [NGRP-1:0] active, active_nx;
    logic          cyc_end, bnd, clear_cnt;
    phase_e        ph [NGRP];

    assign cyc_end = (cyc_cnt == CW'(STEP_CYC - 1));
    assign bnd     = cyc_end && (step_idx == SW'(STEPS - 1));
    // Group that enters RAMP_UP when the current phase ends.
    assign gnext   = gphase + 2'd1;

    // State register (also holds the per-group active bits).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            active <= '0;
        end else begin
            state  <= state_nx;
            active <= active_nx;
        end
    end

    // Next-state logic. A group only changes its active bit at a boundary
    // where it would be entering RAMP_UP, i.e. while it sits at level 0.
    always_comb begin
        state_nx  = state;
        active_nx = active;
        unique case (state)
            IDLE: begin
                if (run_req) begin
                    state_nx  = FILL;
                    active_nx = NGRP'(1);
                end
            end
            FILL: begin
                if (bnd) active_nx[gnext] = run_req;
                if (!run_req)                       state_nx = DRAIN;
                else if (bnd && gphase == 2'd2)     state_nx = RUN;
            end
            RUN: begin
                if (bnd) active_nx[gnext] = run_req;
                if (!run_req) state_nx = DRAIN;
            end
            DRAIN: begin
                if (bnd) active_nx[gnext] = 1'b0;
                if (active_nx == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counters run in every non-IDLE state and are held at 0 otherwise,
    // including on the edge that returns to IDLE.
    assign clear_cnt = (state == IDLE) || (state_nx == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            step_idx <= '0;
            gphase   <= '0;
        end else if (clear_cnt) begin
            cyc_cnt  <= '0;
            step_idx <= '0;
            gphase   <= '0;
        end else begin
            cyc_cnt <= cyc_end ? '0 : cyc_cnt + CW'(1);
            if (cyc_end) step_idx <= bnd ? '0 : step_idx + SW'(1);
            if (bnd)     gphase   <= gphase + 2'd1;
        end
    end

    // Output logic.
    always_comb begin
        busy       = (state != IDLE);
        phase_tick = (state != IDLE) && bnd;
        dbg_state  = state;
        grp_phase  = '0;
        for (int g = 0; g < NGRP; g++) begin
            ph[g] = active[g] ? phase_e'(gphase - 2'(g)) : PH_WAIT;
            grp_phase[2*g +: 2] = ph[g];
        end
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        adiabatic_ramp_gen #(
            .STEPS (STEPS)
        ) u_ramp (
            .clk        (clk),
            .rst        (rst),
            .phase      (ph[g]),
            .step_idx   (step_idx),
            .clkpos_lvl (clkpos_lvl[LW*g +: LW]),
            .clkneg_lvl (clkneg_lvl[LW*g +: LW])
        );
    end

endmodule

// File: tb/tb_adiabatic_pclk_sequencer.sv
// Bench for adiabatic_pclk_sequencer with STEPS=4, STEP_CYC=2 (8-cycle phases).
// A timeline model (cycles since start, per-group powered flags) predicts
// every output each cycle; a negedge monitor compares against the DUT.
module tb_adiabatic_pclk_sequencer;

    localparam int STEPS    = 4;
    localparam int STEP_CYC = 2;
    localparam int PH_LEN   = STEPS * STEP_CYC;
    localparam int LW       = 3;
    localparam int EW       = 2 + 8 + 2 * 4 * LW;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_req;
    logic        busy;
    logic        phase_tick;
    logic [7:0]  grp_phase;
    logic [11:0] clkpos_lvl;
    logic [11:0] clkneg_lvl;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    int start_tab[16] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};

    adiabatic_pclk_sequencer #(
        .STEPS    (STEPS),
        .STEP_CYC (STEP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_req    (run_req),
        .busy       (busy),
        .phase_tick (phase_tick),
        .grp_phase  (grp_phase),
        .clkpos_lvl (clkpos_lvl),
        .clkneg_lvl (clkneg_lvl),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int level_of(input int ph, input int step);
        case (ph)
            0:       return step + 1;
            1:       return STEPS;
            2:       return STEPS - 1 - step;
            default: return 0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    bit          m_on;
    bit          m_drain;
    int          t;
    logic [3:0]  m_act;
    int          cur_ph [4];
    int          cur_step;
    logic [LW-1:0] m_pos [4];

    always @(posedge clk or posedge rst) begin : model
        logic [EW-1:0] e;
        logic [7:0]    e_ph;
        logic [11:0]   e_pos;
        logic [11:0]   e_neg;
        int            p;
        if (rst) begin
            m_on = 0; m_drain = 0; t = 0; m_act = '0; cur_step = 0;
            for (int g = 0; g < 4; g++) begin
                cur_ph[g] = 3;
                m_pos[g]  = '0;
            end
            exp_q.delete();
        end else begin
            // Levels appearing after this edge reflect the cycle just ended.
            for (int g = 0; g < 4; g++) m_pos[g] = LW'(level_of(cur_ph[g], cur_step));
            if (!m_on) begin
                if (run_req) begin
                    m_on = 1; m_drain = 0; t = 0; m_act = 4'b0001;
                end
            end else begin
                if (!run_req) m_drain = 1;
                if (t % PH_LEN == PH_LEN - 1) begin
                    t++;
                    // Group entering RAMP_UP is powered only while not draining.
                    m_act[(t / PH_LEN) % 4] = !m_drain;
                    if (m_act == 4'b0000) begin
                        m_on = 0; t = 0;
                    end
                end else begin
                    t++;
                end
            end
            p        = (t / PH_LEN) % 4;
            cur_step = m_on ? (t % PH_LEN) / STEP_CYC : 0;
            for (int g = 0; g < 4; g++)
                cur_ph[g] = (m_on && m_act[g]) ? (p - g + 4) % 4 : 3;
        end
        for (int g = 0; g < 4; g++) begin
            e_ph[2*g +: 2]   = 2'(cur_ph[g]);
            e_pos[LW*g +: LW] = m_pos[g];
`ifdef ADIABATIC_CLKNEG_EN
            e_neg[LW*g +: LW] = LW'(STEPS) - m_pos[g];
`else
            e_neg[LW*g +: LW] = '0;
`endif
        end
        e = {m_on, (m_on && (t % PH_LEN == PH_LEN - 1)), e_ph, e_pos, e_neg};
        exp_q.push_back(e);
    end

    // ---------------- monitor / scoreboard ----------------
    logic [11:0] prev_pos;
    bit          prev_valid = 0;

    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        bit            step_ok;
        int            d;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy",       busy,       e[33]);
            chk("phase_tick", phase_tick, e[32]);
            chk("grp_phase",  grp_phase,  e[31:24]);
            chk("clkpos_lvl", clkpos_lvl, e[23:12]);
            chk("clkneg_lvl", clkneg_lvl, e[11:0]);
        end
        if (prev_valid && !rst) begin
            step_ok = 1;
            for (int g = 0; g < 4; g++) begin
                d = int'(clkpos_lvl[LW*g +: LW]) - int'(prev_pos[LW*g +: LW]);
                if (d > 1 || d < -1) step_ok = 0;
            end
            chk("adiabatic_step", step_ok, 1);
        end
        prev_pos   = clkpos_lvl;
        prev_valid = !rst;
    end

    // ---------------- driver tasks ----------------
    task automatic set_run(input logic v);
        @(posedge clk);
        #2 run_req = v;
    endtask

    task automatic drain_and_wait(input int limit, input bit early);
        int n;
        logic [7:0] prev;
        bit bad;
        set_run(1'b0);
        n = 0;
        prev = grp_phase;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
            bad = 0;
            for (int g = 0; g < 4; g++)
                if (prev[2*g +: 2] == 2'd3 && grp_phase[2*g +: 2] == 2'd0) bad = 1;
            chk("drain_no_rampup", bad, 0);
            if (early) chk("early_g23_wait", grp_phase[7:4], 4'hF);
            prev = grp_phase;
        end
        chk("drain_done_busy", busy, 0);
        chk("drain_within_32", (n <= 4 * PH_LEN), 1);
    endtask

    task automatic reset_pulse_check;
        @(posedge clk);
        #2 rst = 1; run_req = 0;
        #1;
        chk("rst_busy",      busy,       0);
        chk("rst_tick",      phase_tick, 0);
        chk("rst_grp_phase", grp_phase,  8'hFF);
        chk("rst_clkpos",    clkpos_lvl, 0);
`ifdef ADIABATIC_CLKNEG_EN
        chk("rst_clkneg",    clkneg_lvl, {3'd4, 3'd4, 3'd4, 3'd4});
`else
        chk("rst_clkneg",    clkneg_lvl, 0);
`endif
        repeat (2) @(posedge clk);
        #2 rst = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ticks;
        int n;
        logic [3:0] seen;

        rst = 1; run_req = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Start-up: group 0 ramp, group 1 follows one phase later.
        set_run(1'b1);
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("start_g0_lvl", clkpos_lvl[2:0], start_tab[k]);
            if (k == 7) chk("start_g1_before", clkpos_lvl[5:3], 0);
            if (k == 8) chk("start_g1_first", clkpos_lvl[5:3], 1);
        end

        // Steady state after fill.
        repeat (16) @(posedge clk);
        ticks = 0;
        repeat (64) begin
            @(negedge clk);
            seen = '0;
            for (int g = 0; g < 4; g++) seen[grp_phase[2*g +: 2]] = 1'b1;
            chk("steady_perm", seen, 4'hF);
            ticks += int'(phase_tick);
        end
        chk("steady_tick_count", ticks, 64 / PH_LEN);

        // Drain from RUN at a random point in the phase.
        repeat ($urandom_range(0, 7)) @(posedge clk);
        drain_and_wait(40, 1'b0);

        // Early stop during fill, once group 1 has started.
        set_run(1'b1);
        n = 0;
        while (grp_phase[3:2] == 2'd3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("early_g1_started", (grp_phase[3:2] != 2'd3), 1);
        repeat ($urandom_range(0, 5)) @(posedge clk);
        drain_and_wait(40, 1'b1);

        // Random run_req activity, including restarts and drains.
        repeat (400) begin
            @(posedge clk);
            #2 if ($urandom_range(0, 15) == 0) run_req = ~run_req;
        end
        drain_and_wait(40, 1'b0);

        // Reset in the middle of a run.
        set_run(1'b1);
        repeat ($urandom_range(20, 50)) @(posedge clk);
        reset_pulse_check();
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_idle", busy, 0);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
